ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Two-port arbiter and sequencer in front of the byte-lane `single_port_ram` (1 KB, 8/16/32-bit accesses, one-cycle registered read). It shares the RAM between the core's data port (loads/stores) and its instruction-fetch port. It issues exactly one RAM command at a time and returns read data or a write acknowledge to the winning requester. Illegal accesses are rejected with an error response before they reach the RAM.

## Interface
- `MAX_DATA_BURST`, default 4: consecutive data-port grants allowed while a fetch is pending before fetch is forced to win; legal range 1..15.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `d_req` input 1: data-port request.
- `d_we` input 1: 1 = write, 0 = read.
- `d_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `d_addr` input 32: byte address.
- `d_wdata` input 32: write data, lane-positioned as the RAM expects.
- `d_gnt` output 1: one-cycle pulse; request accepted.
- `d_rvalid` output 1: one-cycle pulse; response for the last granted data request.
- `d_rdata` output 32: read data (zero-extended by the RAM); 0 for writes and errors.
- `d_err` output 1: qualifies `d_rvalid`; access was rejected.
- `i_req` input 1: fetch request; always a 32-bit read.
- `i_addr` input 32: fetch byte address.
- `i_gnt` output 1: one-cycle pulse; fetch accepted.
- `i_rvalid` output 1: one-cycle pulse; response for the last granted fetch.
- `i_rdata` output 32: fetched word; 0 on error.
- `i_err` output 1: qualifies `i_rvalid`.
- `ram_we` output 1: RAM write enable.
- `ram_size` output 2: RAM size select.
- `ram_addr` output 32: RAM address.
- `ram_wdata` output 32: RAM write data.
- `ram_rdata` input 32: RAM read_data.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is present: assert the winner's `x_gnt` combinationally in the same cycle.
  - Capture the winner's fields into the command registers (`cmd_src`, `cmd_we`, `cmd_size`, `cmd_addr`, `cmd_wdata`, `cmd_err`).
  - Go to BUSY.
  - Fetch commands capture `we` = 0 and `size` = 10.
- BUSY:
  - `ram_addr`, `ram_size` and `ram_wdata` are driven from the command registers. These outputs hold their values in every state.
  - `ram_we` = BUSY & `cmd_we` & !`cmd_err` & !`rst`.
  - Always go to RESP.
- RESP:
  - Assert `x_rvalid` for `cmd_src`.
  - `x_rdata` = `ram_rdata` for an error-free read, otherwise 0.
  - `x_err` = `cmd_err`.
  - In the same cycle, arbitrate again as in IDLE. If a request is present, grant it and go to BUSY; otherwise go to IDLE.
- Error (`cmd_err` = 1) when any of the following hold:
  - `addr[31:10]` != 0;
  - size = 11;
  - size = 01 with `addr[0]` = 1;
  - size = 10 with `addr[1:0]` != 0.
- Errored commands never write the RAM but still take the full BUSY→RESP sequence.
- Arbitration (IDLE or RESP with requests present):
  - Data wins by default.
  - Fetch wins if only `i_req` is present, or if `starve_cnt` = `MAX_DATA_BURST` and `i_req` = 1.
- `starve_cnt` (4 bits):
  - Increments on each data grant while `i_req` = 1.
  - Clears on a fetch grant or on any cycle with `i_req` = 0.
  - Saturates at `MAX_DATA_BURST`.
- Requester rules:
  - Hold `req` and all request fields stable until `gnt`.
  - `req` may change only after `gnt`.
  - At most one outstanding request per port is implied by the FSM.
- Simultaneous `d_req`/`i_req`: exactly one grant per arbitration cycle; `d_gnt` and `i_gnt` are never both high.

## Timing
- Reset values:
  - state = IDLE;
  - `starve_cnt` = 0;
  - all command registers = 0;
  - all outputs = 0, including `ram_we`, `ram_addr`, `ram_size` and `ram_wdata`.
- Latency from grant in cycle N:
  - RAM sampled at the end of N+1;
  - `x_rvalid` in cycle N+2.
- Throughput: back-to-back grants every 2 cycles (grant in RESP overlaps the response).
- Reset mid-operation:
  - `rst` in a BUSY cycle suppresses `ram_we`, so no write commits.
  - No `rvalid` is produced for an abandoned command.
  - Next state is IDLE.
- A request asserted in a BUSY cycle is not granted until the following RESP cycle.

## Test plan
- Single word write then read:
  - Write `d_addr` = 0x10, `d_size` = 10, `d_wdata` = 0xDEADBEEF → `d_gnt` in N, `ram_we` in N+1, `d_rvalid` in N+2 with `d_rdata` = 0, `d_err` = 0.
  - Read back 0x10 → `d_rdata` = 0xDEADBEEF in its N+2.
- Byte/halfword reads after the above:
  - Byte read 0x13 → 0x000000DE.
  - Halfword read 0x12 → 0x0000DEAD.
  - Halfword read 0x11 → `d_err` = 1, `d_rdata` = 0.
- Errors:
  - Word write to 0x400 → `d_err` = 1, `ram_we` never high, and a later read of 0x000 is unchanged.
  - Size 11 → `d_err` = 1.
- Contention:
  - `d_req` and `i_req` held high continuously with `MAX_DATA_BURST` = 4 → grant sequence D,D,D,D,I,D,D,D,D,I.
  - Grants 2 cycles apart; never two grants in one cycle.
- Fetch only: `i_addr` = 0x10 → `i_rvalid` in N+2 with `i_rdata` = 0xDEADBEEF; `i_addr` = 0x12 → `i_err` = 1.
- Reset during BUSY of a word write to 0x20 of 0x12345678 → no `d_rvalid`, all outputs 0 next cycle, a later read of 0x20 returns the prior contents.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Bundles the data-port, fetch-port and RAM command signals of the arbiter.
// The slave modport is the arbiter's view; master is the core/RAM side.
interface ram_access_arbiter_if;
  // Data port (loads/stores)
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  // Instruction-fetch port (always 32-bit reads)
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  // RAM command side
  logic        ram_we;
  logic [1:0]  ram_size;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  d_req, d_we, d_size, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output ram_we, ram_size, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output d_req, d_we, d_size, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  ram_we, ram_size, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares the single-port byte-lane RAM between the data and fetch ports.
// One command in flight at a time: grant (IDLE/RESP) -> BUSY (RAM access)
// -> RESP (response, with a new grant overlapping it). Illegal accesses are
// flagged at grant time and never drive the RAM write enable.
module ram_access_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input logic                 clk,
  input logic                 rst,
  ram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {SRC_D = 1'b0, SRC_I = 1'b1} src_e;

  typedef struct packed {
    src_e        src;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } cmd_t;

  localparam logic [3:0] MAX_BURST = 4'(MAX_DATA_BURST);

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic        d_gnt, i_gnt;
  logic        arb_en, i_wins, resp_valid;
  logic [31:0] resp_rdata;

  // Out-of-range, illegal-size or misaligned accesses never reach the RAM.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    return (addr[31:10] != 22'd0) ||
           (size == 2'b11) ||
           ((size == 2'b01) && addr[0]) ||
           ((size == 2'b10) && (addr[1:0] != 2'b00));
  endfunction

  // Next state, arbitration, command capture and starvation counting.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    cmd_d        = cmd_q;
    starve_cnt_d = starve_cnt_q;
    d_gnt        = 1'b0;
    i_gnt        = 1'b0;

    arb_en = ((state_q == IDLE) || (state_q == RESP)) && !rst;
    i_wins = bus.i_req && (!bus.d_req || (starve_cnt_q == MAX_BURST));

    unique case (state_q)
      BUSY:    state_d = RESP;
      default: state_d = IDLE;
    endcase

    if (arb_en && (bus.d_req || bus.i_req)) begin
      state_d = BUSY;
      if (i_wins) begin
        i_gnt       = 1'b1;
        cmd_d.src   = SRC_I;
        cmd_d.we    = 1'b0;
        cmd_d.size  = 2'b10;
        cmd_d.addr  = bus.i_addr;
        cmd_d.wdata = 32'd0;
        cmd_d.err   = access_err(2'b10, bus.i_addr);
      end else begin
        d_gnt       = 1'b1;
        cmd_d.src   = SRC_D;
        cmd_d.we    = bus.d_we;
        cmd_d.size  = bus.d_size;
        cmd_d.addr  = bus.d_addr;
        cmd_d.wdata = bus.d_wdata;
        cmd_d.err   = access_err(bus.d_size, bus.d_addr);
      end
    end

    // Counts data grants that bypassed a waiting fetch, saturating at the limit.
    if (!bus.i_req || i_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q < MAX_BURST)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State, command and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response path: read data only for error-free reads, zero otherwise.
  always_comb begin
    resp_valid = (state_q == RESP) && !rst;
    resp_rdata = (!cmd_q.we && !cmd_q.err) ? bus.ram_rdata : 32'd0;
  end

  assign bus.d_gnt    = d_gnt;
  assign bus.i_gnt    = i_gnt;

  assign bus.d_rvalid = resp_valid && (cmd_q.src == SRC_D);
  assign bus.d_rdata  = bus.d_rvalid ? resp_rdata : 32'd0;
  assign bus.d_err    = bus.d_rvalid && cmd_q.err;

  assign bus.i_rvalid = resp_valid && (cmd_q.src == SRC_I);
  assign bus.i_rdata  = bus.i_rvalid ? resp_rdata : 32'd0;
  assign bus.i_err    = bus.i_rvalid && cmd_q.err;

  // Reset in a BUSY cycle masks the write so an abandoned store never commits.
  assign bus.ram_we    = (state_q == BUSY) && cmd_q.we && !cmd_q.err && !rst;
  assign bus.ram_size  = cmd_q.size;
  assign bus.ram_addr  = cmd_q.addr;
  assign bus.ram_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 1 KB byte-lane RAM.
module tb_ram_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_access_arbiter_if bus ();

  ram_access_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural RAM: little-endian, lane-positioned writes, registered
  // right-aligned zero-extended reads.
  logic [7:0] mem [0:1023];

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] addr, input logic [1:0] size);
    logic [9:0]  a;
    logic [31:0] w;
    a = addr[9:0];
    w = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    if (size == 2'b00) return {24'd0, w[7:0]};
    if (size == 2'b01) return {16'd0, w[15:0]};
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (k < nbytes(bus.ram_size))
          mem[bus.ram_addr[9:0] + 10'(k)] <=
            bus.ram_wdata[8*((int'(bus.ram_addr[1:0]) + k) % 4) +: 8];
      end
    end
    bus.ram_rdata <= ram_read(bus.ram_addr, bus.ram_size);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'b00;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'd0;
  endtask

  // One data-port transaction: grant in N, RAM command in N+1, response in N+2.
  task automatic data_access(input string tag, input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size;
    bus.d_addr = addr; bus.d_wdata = wdata;
    #1;
    check({tag, " d_gnt"}, 32'(bus.d_gnt), 32'd1);
    check({tag, " i_gnt"}, 32'(bus.i_gnt), 32'd0);
    @(negedge clk);
    bus.d_req = 1'b0;
    #1;
    check({tag, " ram_we"},    32'(bus.ram_we), 32'(we && !exp_err));
    check({tag, " ram_addr"},  bus.ram_addr, addr);
    check({tag, " ram_size"},  32'(bus.ram_size), 32'(size));
    check({tag, " ram_wdata"}, bus.ram_wdata, wdata);
    check({tag, " d_rvalid early"}, 32'(bus.d_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'd1);
    check({tag, " d_err"},    32'(bus.d_err), 32'(exp_err));
    check({tag, " d_rdata"},  bus.d_rdata, exp_rdata);
  endtask

  // One fetch transaction with the same N / N+1 / N+2 timing.
  task automatic fetch_access(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = addr;
    #1;
    check({tag, " i_gnt"}, 32'(bus.i_gnt), 32'd1);
    check({tag, " d_gnt"}, 32'(bus.d_gnt), 32'd0);
    @(negedge clk);
    bus.i_req = 1'b0;
    #1;
    check({tag, " ram_we"},   32'(bus.ram_we), 32'd0);
    check({tag, " ram_size"}, 32'(bus.ram_size), 32'd2);
    @(negedge clk);
    #1;
    check({tag, " i_rvalid"}, 32'(bus.i_rvalid), 32'd1);
    check({tag, " i_err"},    32'(bus.i_err), 32'(exp_err));
    check({tag, " i_rdata"},  bus.i_rdata, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] i_pattern;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    idle_inputs();
    rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset d_gnt",     32'(bus.d_gnt), 32'd0);
    check("reset i_gnt",     32'(bus.i_gnt), 32'd0);
    check("reset d_rvalid",  32'(bus.d_rvalid), 32'd0);
    check("reset i_rvalid",  32'(bus.i_rvalid), 32'd0);
    check("reset ram_we",    32'(bus.ram_we), 32'd0);
    check("reset ram_addr",  bus.ram_addr, 32'd0);
    check("reset ram_size",  32'(bus.ram_size), 32'd0);
    check("reset ram_wdata", bus.ram_wdata, 32'd0);

    // Word write then read back, then sub-word reads of the same word
    data_access("wr10",   1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    data_access("rd10",   1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    data_access("rdb13",  1'b0, 2'b00, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    data_access("rdh12",  1'b0, 2'b01, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    data_access("rdh11",  1'b0, 2'b01, 32'h11, 32'h0, 32'h0, 1'b1);

    // Out-of-range write must not alias onto address 0
    data_access("wr00",   1'b1, 2'b10, 32'h0,   32'h11223344, 32'h0, 1'b0);
    data_access("wr400",  1'b1, 2'b10, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1);
    data_access("rd00",   1'b0, 2'b10, 32'h0,   32'h0, 32'h11223344, 1'b0);
    data_access("size11", 1'b0, 2'b11, 32'h4,   32'h0, 32'h0, 1'b1);

    // Fetch only
    fetch_access("if10", 32'h10, 32'hDEADBEEF, 1'b0);
    fetch_access("if12", 32'h12, 32'h0, 1'b1);

    // Contention: both requests held high; expect D,D,D,D,I,D,D,D,D,I
    i_pattern = 10'b10000_10000;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h10;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c % 2 == 0) begin
        check($sformatf("cont d_gnt c%0d", c), 32'(bus.d_gnt), 32'(!i_pattern[c/2]));
        check($sformatf("cont i_gnt c%0d", c), 32'(bus.i_gnt), 32'(i_pattern[c/2]));
      end else begin
        check($sformatf("cont gap c%0d", c), 32'({bus.d_gnt, bus.i_gnt}), 32'd0);
      end
      if (c == 2) check("cont d_rdata c2", bus.d_rdata, 32'hDEADBEEF);
      if (c == 10) begin
        check("cont i_rvalid c10", 32'(bus.i_rvalid), 32'd1);
        check("cont i_rdata c10",  bus.i_rdata, 32'h11223344);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("cont final i_rvalid", 32'(bus.i_rvalid), 32'd1);
    check("cont final gnt", 32'({bus.d_gnt, bus.i_gnt}), 32'd0);

    // Reset during the BUSY cycle of a write
    data_access("wr20", 1'b1, 2'b10, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b10;
    bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
    #1;
    check("rstbusy d_gnt", 32'(bus.d_gnt), 32'd1);
    @(negedge clk);
    bus.d_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rstbusy ram_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rstbusy d_rvalid",  32'(bus.d_rvalid), 32'd0);
    check("rstbusy ram_we2",   32'(bus.ram_we), 32'd0);
    check("rstbusy ram_addr",  bus.ram_addr, 32'd0);
    check("rstbusy ram_wdata", bus.ram_wdata, 32'd0);
    check("rstbusy ram_size",  32'(bus.ram_size), 32'd0);
    @(negedge clk);
    #1;
    check("rstbusy d_rvalid2", 32'(bus.d_rvalid), 32'd0);
    data_access("rd20", 1'b0, 2'b10, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
